// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Optional input FIFO in uart_tx_gen is enabled by defining UART_TX_FIFO_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Wide enough to index up to 9 data bits or 2 stop bits.
    localparam int BIT_CNT_W = 4;

    // Even parity is the XOR of the word; odd parity is its inverse.
    function automatic logic calc_parity(input logic [8:0] word, input int mode);
        return (^word) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words ahead of the transmitter.
// Instantiated by uart_tx_gen only when UART_TX_FIFO_EN is defined.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_gen.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
// Define UART_TX_FIFO_EN to buffer words in a FIFO_DEPTH-entry input FIFO.
module uart_tx_gen
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 2604,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 TX,
    output logic                 full,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 overrun
);

    localparam int                   BAUD_W     = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0]    BAUD_LAST  = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_CNT_W-1:0] DATA_LAST  = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] STOP_LAST  = BIT_CNT_W'(STOP_BITS - 1);
    localparam bit                   HAS_PARITY = (PARITY != PAR_NONE);

    tx_state_t              state, state_d;
    logic [BAUD_W-1:0]      baud_cnt, baud_d;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_d;
    logic [DATA_BITS-1:0]   shift_reg, shift_d, load_word;
    logic                   par_bit, par_d;
    logic                   done_d;
    logic                   bit_end;
    logic                   accept;
    logic                   word_avail;
    logic                   load;

    assign busy    = (state != ST_IDLE);
    assign bit_end = (baud_cnt == BAUD_LAST);

`ifdef UART_TX_FIFO_EN
    localparam int               CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = FIFO_DEPTH[CNT_W-1:0];

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .wdata (tx_data),
        .pop   (load),
        .rdata (load_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign accept     = trmt && !fifo_full;
    assign word_avail = !fifo_empty;
    assign full       = (fifo_count == FULL_CNT);
`else
    // The shift register doubles as the only holding slot, so words are taken only in IDLE.
    assign accept     = trmt && !busy;
    assign word_avail = accept;
    assign load_word  = tx_data;
    assign full       = busy;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_cnt;
        shift_d = shift_reg;
        par_d   = par_bit;
        done_d  = tx_done;
        load    = 1'b0;
        TX      = 1'b1;

        if (state != ST_IDLE) baud_d = bit_end ? '0 : baud_cnt + 1'b1;

        unique case (state)
            ST_IDLE: begin
                if (word_avail) load = 1'b1;
            end
            ST_START: begin
                TX = 1'b0;
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                TX = shift_reg[0];
                if (bit_end) begin
                    shift_d = shift_reg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                TX = par_bit;
                if (bit_end) begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_d = '0;
                        if (word_avail) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        bit_d = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Parity is fixed from the loaded word, never from the shifting register.
        if (load) begin
            state_d = ST_START;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = load_word;
            par_d   = calc_parity(9'(load_word), PARITY);
        end

        if (accept) done_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            tx_done   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_d;
            baud_cnt  <= baud_d;
            bit_cnt   <= bit_d;
            shift_reg <= shift_d;
            par_bit   <= par_d;
            tx_done   <= done_d;
            overrun   <= trmt && full;
        end
    end

endmodule

// File: tb/tb_uart_tx_gen.sv
// Directed bench for uart_tx_gen: 8N1, 7E2 and 7O2 instances at 16 clocks per bit.
// FIFO-specific sequences are compiled in when UART_TX_FIFO_EN is defined.
module tb_uart_tx_gen;

    localparam int BD = 16;

    typedef struct {
        string       name;
        int          inst;
        logic [8:0]  word;
        logic [10:0] bits;   // line levels, bit 0 = start bit
        int          nbits;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] trmt;
    logic [2:0] tx, full, busy, done, ovr;
    logic [7:0] d0;
    logic [6:0] d1, d2;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [6];
    logic [7:0] fifo_words [6] = '{8'h01, 8'h80, 8'hA5, 8'h5A, 8'hFF, 8'h00};

    always #5 clk = ~clk;

    uart_tx_gen #(.DATA_BITS(8), .BAUD_DIV(BD), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .trmt(trmt[0]), .tx_data(d0), .TX(tx[0]),
        .full(full[0]), .busy(busy[0]), .tx_done(done[0]), .overrun(ovr[0]));

    uart_tx_gen #(.DATA_BITS(7), .BAUD_DIV(BD), .PARITY(2), .STOP_BITS(2)) u_7e2 (
        .clk(clk), .rst(rst), .trmt(trmt[1]), .tx_data(d1), .TX(tx[1]),
        .full(full[1]), .busy(busy[1]), .tx_done(done[1]), .overrun(ovr[1]));

    uart_tx_gen #(.DATA_BITS(7), .BAUD_DIV(BD), .PARITY(1), .STOP_BITS(2)) u_7o2 (
        .clk(clk), .rst(rst), .trmt(trmt[2]), .tx_data(d2), .TX(tx[2]),
        .full(full[2]), .busy(busy[2]), .tx_done(done[2]), .overrun(ovr[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_data(input int inst, input logic [8:0] word);
        case (inst)
            0:       d0 = word[7:0];
            1:       d1 = word[6:0];
            default: d2 = word[6:0];
        endcase
    endtask

    // Entered #1 after the edge that starts bit 0; returns #1 after the last clock of the frame.
    task automatic check_bits(input string tag, input int inst, input logic [10:0] bits,
                              input int nbits, input int inject, input int first_wait);
        for (int i = 0; i < nbits; i++) begin
            if (i == inject) begin
                repeat (4) @(posedge clk);
                #1 set_data(inst, 9'h1FF);
                trmt[inst] = 1'b1;
                @(posedge clk);
                #1 trmt[inst] = 1'b0;
                check({tag, "_overrun_pulse"}, ovr[inst], 1);
                @(posedge clk);
                #1 check({tag, "_overrun_clear"}, ovr[inst], 0);
                repeat (2) @(posedge clk);
            end else begin
                repeat ((i == 0) ? first_wait : 8) @(posedge clk);
            end
            #1 check($sformatf("%s_bit%0d", tag, i), tx[inst], bits[i]);
            repeat ((i == nbits - 1) ? 7 : 8) @(posedge clk);
        end
        #1;
    endtask

    task automatic run_frame(input string tag, input int inst, input logic [8:0] word,
                             input logic [10:0] bits, input int nbits, input int inject);
        set_data(inst, word);
        trmt[inst] = 1'b1;
        @(posedge clk);
        #1 trmt[inst] = 1'b0;
        check({tag, "_done_clr_on_accept"}, done[inst], 0);
`ifdef UART_TX_FIFO_EN
        check({tag, "_fifo_latency_idle"}, tx[inst], 1);
        @(posedge clk);
        #1;
`endif
        check({tag, "_start_edge"}, tx[inst], 0);
        check_bits(tag, inst, bits, nbits, inject, 8);
        check({tag, "_busy_last_clk"}, busy[inst], 1);
        check({tag, "_done_last_clk"}, done[inst], 0);
        @(posedge clk);
        #1 check({tag, "_done_set"}, done[inst], 1);
        check({tag, "_busy_clear"}, busy[inst], 0);
        check({tag, "_tx_idle"}, tx[inst], 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic sticky;

        vecs[0] = '{"8n1_a5", 0, 9'h0A5, 11'({1'b1, 8'hA5, 1'b0}), 10};
        vecs[1] = '{"8n1_3c", 0, 9'h03C, 11'({1'b1, 8'h3C, 1'b0}), 10};
        vecs[2] = '{"7e2_55", 1, 9'h055, {2'b11, 1'b0, 7'h55, 1'b0}, 11};
        vecs[3] = '{"7e2_7f", 1, 9'h07F, {2'b11, 1'b1, 7'h7F, 1'b0}, 11};
        vecs[4] = '{"7o2_55", 2, 9'h055, {2'b11, 1'b1, 7'h55, 1'b0}, 11};
        vecs[5] = '{"7o2_7f", 2, 9'h07F, {2'b11, 1'b0, 7'h7F, 1'b0}, 11};

        rst  = 1'b1;
        trmt = '0;
        d0   = '0;
        d1   = '0;
        d2   = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_tx_%0d", k), tx[k], 1);
            check($sformatf("rst_done_%0d", k), done[k], 0);
            check($sformatf("rst_full_%0d", k), full[k], 0);
            check($sformatf("rst_busy_%0d", k), busy[k], 0);
            check($sformatf("rst_overrun_%0d", k), ovr[k], 0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++)
            run_frame(vecs[v].name, vecs[v].inst, vecs[v].word, vecs[v].bits, vecs[v].nbits, -1);

        // tx_done holds through a long idle stretch, then clears on the next accept.
        sticky = 1'b1;
        repeat (100) begin
            @(posedge clk);
            #1 if (done[0] !== 1'b1) sticky = 1'b0;
        end
        check("done_sticky_100", sticky, 1);
        run_frame("after_sticky", 0, 9'h0C3, 11'({1'b1, 8'hC3, 1'b0}), 10, -1);

`ifndef UART_TX_FIFO_EN
        // A request during a frame is dropped and leaves the frame untouched.
        run_frame("drop_midframe", 0, 9'h0A5, 11'({1'b1, 8'hA5, 1'b0}), 10, 3);
        repeat (20) @(posedge clk);
        #1 check("drop_not_sent", busy[0], 0);
`endif

        // Reset in the middle of data bit 3, with a second word requested during the frame.
        set_data(0, 9'h0A5);
        trmt[0] = 1'b1;
        @(posedge clk);
        #1 trmt[0] = 1'b0;
`ifdef UART_TX_FIFO_EN
        @(posedge clk);
        #1;
`endif
        set_data(0, 9'h0F0);
        trmt[0] = 1'b1;
        @(posedge clk);
        #1 trmt[0] = 1'b0;
        repeat (70) @(posedge clk);
        #1 check("pre_reset_data_bit3", tx[0], 0);
        rst = 1'b1;
        @(posedge clk);
        #1 check("reset_mid_tx", tx[0], 1);
        check("reset_mid_busy", busy[0], 0);
        check("reset_mid_done", done[0], 0);
        check("reset_mid_full", full[0], 0);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("reset_no_pending", busy[0], 0);
        run_frame("post_reset", 0, 9'h03C, 11'({1'b1, 8'h3C, 1'b0}), 10, -1);

`ifdef UART_TX_FIFO_EN
        // Six requests on consecutive edges: four queue, one is popped, the sixth overruns.
        for (int k = 0; k < 6; k++) begin
            d0      = fifo_words[k];
            trmt[0] = 1'b1;
            @(posedge clk);
            #1 check($sformatf("fifo_full_push%0d", k), full[0], (k >= 4));
            check($sformatf("fifo_overrun_push%0d", k), ovr[0], (k == 5));
        end
        trmt[0] = 1'b0;
        @(posedge clk);
        #1 check("fifo_overrun_clear", ovr[0], 0);
        for (int j = 0; j < 5; j++) begin
            check_bits($sformatf("fifo_frame%0d", j), 0, 11'({1'b1, fifo_words[j], 1'b0}), 10, -1,
                       (j == 0) ? 3 : 8);
            check($sformatf("fifo_full_end%0d", j), full[0], (j == 0));
            check($sformatf("fifo_done_end%0d", j), done[0], 0);
            if (j == 0) begin
                d0      = 8'h77;
                trmt[0] = 1'b1;
            end
            @(posedge clk);
            #1 trmt[0] = 1'b0;
            if (j == 0) check("fifo_drop_on_free_edge", ovr[0], 1);
            if (j < 4) begin
                check($sformatf("fifo_b2b_start%0d", j), tx[0], 0);
                check($sformatf("fifo_b2b_busy%0d", j), busy[0], 1);
            end else begin
                check("fifo_last_done", done[0], 1);
                check("fifo_last_busy", busy[0], 0);
            end
        end
        repeat (20) @(posedge clk);
        #1 check("fifo_no_extra_frame", busy[0], 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
